// File: rtl/pc_select.sv
// pc_select: next-PC generation with boot/sequential/redirect/trap selection and stall-safe redirect latching
module pc_select #(
  parameter logic [29:0] RESET_VECTOR = 30'h0000_0000,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid_i,
  input  logic [29:0]      redirect_pc_i,
  input  logic             trap_valid_i,
  input  logic [29:0]      trap_pc_i,
  input  logic             halt_i,
  output logic [29:0]      pc_o,
  output logic             pc_valid_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);
  typedef enum logic [1:0] {BOOT, RUN, PEND, HALT} state_t;
  state_t           state_q, state_d;
  logic [29:0]      pc_q, pc_d, pend_pc_q, pend_pc_d;
  logic             pend_trap_q, pend_trap_d, flush_q, flush_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      pend_pc_q   <= '0;
      pend_trap_q <= 1'b0;
      flush_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      pend_trap_q <= pend_trap_d;
      flush_q     <= flush_d;
      cnt_q       <= cnt_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    pend_trap_d = pend_trap_q;
    flush_d     = 1'b0;
    case (state_q)
      RUN, HALT: begin
        if (!stall) begin
          if (trap_valid_i || redirect_valid_i) begin
            flush_d = 1'b1;
            pc_d    = trap_valid_i ? trap_pc_i : redirect_pc_i;
            state_d = RUN;
          end else if (state_q == RUN) begin
            if (halt_i) state_d = HALT;
            else pc_d = pc_q + 30'd1;
          end
        end else if (trap_valid_i || redirect_valid_i) begin
          pend_pc_d   = trap_valid_i ? trap_pc_i : redirect_pc_i;
          pend_trap_d = trap_valid_i;
          state_d     = PEND;
        end
      end
      PEND: begin
        if (!stall) begin
          flush_d     = 1'b1;
          pc_d        = trap_valid_i ? trap_pc_i :
                        pend_trap_q ? pend_pc_q :
                        redirect_valid_i ? redirect_pc_i : pend_pc_q;
          pend_trap_d = 1'b0;
          state_d     = RUN;
        end else if (trap_valid_i) begin
          pend_pc_d   = trap_pc_i;
          pend_trap_d = 1'b1;
        end else if (redirect_valid_i && !pend_trap_q) begin
          pend_pc_d = redirect_pc_i;
        end
      end
      default: state_d = RUN;
    endcase
    cnt_d = (flush_d && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  assign pc_o           = pc_q;
  assign pc_valid_o     = (state_q == RUN) || (state_q == PEND);
  assign flush_o        = flush_q;
  assign redirect_cnt_o = cnt_q;
endmodule

// File: tb/tb_pc_select.sv
// tb_pc_select: directed table-driven checks of pc_select, plus halt, reset-in-PEND and counter saturation sequences
module tb_pc_select;
  logic        clk = 1'b0;
  logic        rst, stall, rv, tv, halt;
  logic [29:0] rpc, tpc;
  logic [29:0] pc, pc_s;
  logic        pv, fl, pv_s, fl_s;
  logic [15:0] cnt;
  logic [2:0]  cnt_s;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  pc_select dut (.clk(clk), .rst(rst), .stall(stall), .redirect_valid_i(rv), .redirect_pc_i(rpc),
    .trap_valid_i(tv), .trap_pc_i(tpc), .halt_i(halt), .pc_o(pc), .pc_valid_o(pv),
    .flush_o(fl), .redirect_cnt_o(cnt));

  pc_select #(.CNT_W(3)) dut_s (.clk(clk), .rst(rst), .stall(stall), .redirect_valid_i(rv),
    .redirect_pc_i(rpc), .trap_valid_i(tv), .trap_pc_i(tpc), .halt_i(halt), .pc_o(pc_s),
    .pc_valid_o(pv_s), .flush_o(fl_s), .redirect_cnt_o(cnt_s));

  typedef struct {
    logic r, s, rv;
    logic [29:0] rpc;
    logic tv;
    logic [29:0] tpc;
    logic h;
    logic [29:0] pc;
    logic v, f;
    int c;
  } vec_t;
  vec_t tbl[28];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input int idx, input logic r, s, v_rv, input logic [29:0] v_rpc, input logic v_tv,
                      input logic [29:0] v_tpc, input logic h, input logic [29:0] e_pc,
                      input logic e_v, e_f, input int e_c);
    rst = r; stall = s; rv = v_rv; rpc = v_rpc; tv = v_tv; tpc = v_tpc; halt = h;
    @(posedge clk); #1;
    chk("pc", idx, {2'b0, pc}, {2'b0, e_pc});
    chk("pc_valid", idx, {31'b0, pv}, {31'b0, e_v});
    chk("flush", idx, {31'b0, fl}, {31'b0, e_f});
    chk("cnt", idx, {16'b0, cnt}, e_c);
    chk("cnt_sat", idx, {29'b0, cnt_s}, (e_c > 7) ? 7 : e_c);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 30'h0,        1'b0, 30'h0,   1'b0, 30'h0,        1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 30'h0,        1'b0, 30'h0,   1'b0, 30'h0,        1'b1, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 30'h0,        1'b0, 30'h0,   1'b0, 30'h1,        1'b1, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 30'h0,        1'b0, 30'h0,   1'b0, 30'h2,        1'b1, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 30'h0,        1'b0, 30'h0,   1'b0, 30'h3,        1'b1, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 30'h100,      1'b0, 30'h0,   1'b0, 30'h100,      1'b1, 1'b1, 1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 30'h0,        1'b0, 30'h0,   1'b0, 30'h101,      1'b1, 1'b0, 1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 30'h40,       1'b0, 30'h0,   1'b0, 30'h101,      1'b1, 1'b0, 1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 30'h0,        1'b1, 30'h200, 1'b0, 30'h101,      1'b1, 1'b0, 1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 30'h0,        1'b0, 30'h0,   1'b0, 30'h101,      1'b1, 1'b0, 1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 30'h0,        1'b0, 30'h0,   1'b0, 30'h200,      1'b1, 1'b1, 2};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 30'h0,        1'b0, 30'h0,   1'b0, 30'h201,      1'b1, 1'b0, 2};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 30'h3ffffffe, 1'b0, 30'h0,   1'b0, 30'h3ffffffe, 1'b1, 1'b1, 3};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 30'h0,        1'b0, 30'h0,   1'b0, 30'h3fffffff, 1'b1, 1'b0, 3};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 30'h0,        1'b0, 30'h0,   1'b0, 30'h0,        1'b1, 1'b0, 3};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 30'h0,        1'b0, 30'h0,   1'b0, 30'h1,        1'b1, 1'b0, 3};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 30'h50,       1'b1, 30'h300, 1'b0, 30'h300,      1'b1, 1'b1, 4};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 30'h0,        1'b0, 30'h0,   1'b0, 30'h301,      1'b1, 1'b0, 4};
    tbl[18] = '{1'b1, 1'b0, 1'b1, 30'h10,       1'b0, 30'h0,   1'b0, 30'h10,       1'b1, 1'b1, 5};
    tbl[19] = '{1'b1, 1'b0, 1'b1, 30'h20,       1'b0, 30'h0,   1'b0, 30'h20,       1'b1, 1'b1, 6};
    tbl[20] = '{1'b1, 1'b1, 1'b1, 30'h30,       1'b0, 30'h0,   1'b0, 30'h20,       1'b1, 1'b0, 6};
    tbl[21] = '{1'b1, 1'b1, 1'b1, 30'h31,       1'b0, 30'h0,   1'b1, 30'h20,       1'b1, 1'b0, 6};
    tbl[22] = '{1'b1, 1'b0, 1'b0, 30'h0,        1'b0, 30'h0,   1'b0, 30'h31,       1'b1, 1'b1, 7};
    tbl[23] = '{1'b1, 1'b1, 1'b0, 30'h0,        1'b1, 30'h400, 1'b0, 30'h31,       1'b1, 1'b0, 7};
    tbl[24] = '{1'b1, 1'b1, 1'b1, 30'h41,       1'b0, 30'h0,   1'b0, 30'h31,       1'b1, 1'b0, 7};
    tbl[25] = '{1'b1, 1'b0, 1'b1, 30'h42,       1'b0, 30'h0,   1'b0, 30'h400,      1'b1, 1'b1, 8};
    tbl[26] = '{1'b1, 1'b0, 1'b0, 30'h0,        1'b0, 30'h0,   1'b0, 30'h401,      1'b1, 1'b0, 8};
    tbl[27] = '{1'b1, 1'b0, 1'b0, 30'h0,        1'b0, 30'h0,   1'b1, 30'h401,      1'b0, 1'b0, 8};
    rst = 1'b0; stall = 1'b0; rv = 1'b0; tv = 1'b0; halt = 1'b0; rpc = '0; tpc = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 28; i++)
      step(i, tbl[i].r, tbl[i].s, tbl[i].rv, tbl[i].rpc, tbl[i].tv, tbl[i].tpc, tbl[i].h,
           tbl[i].pc, tbl[i].v, tbl[i].f, tbl[i].c);
    // halted: frozen and invalid, halt_i ignored, exits on redirect
    for (int i = 0; i < 10; i++)
      step(100 + i, 1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, i[0], 30'h401, 1'b0, 1'b0, 8);
    step(110, 1'b1, 1'b0, 1'b1, 30'h80, 1'b0, 30'h0, 1'b0, 30'h80, 1'b1, 1'b1, 9);
    step(111, 1'b1, 1'b0, 1'b0, 30'h0,  1'b0, 30'h0, 1'b1, 30'h80, 1'b0, 1'b0, 9);
    step(112, 1'b1, 1'b1, 1'b1, 30'h90, 1'b0, 30'h0, 1'b0, 30'h80, 1'b1, 1'b0, 9);
    step(113, 1'b1, 1'b0, 1'b0, 30'h0,  1'b0, 30'h0, 1'b0, 30'h90, 1'b1, 1'b1, 10);
    step(114, 1'b1, 1'b0, 1'b0, 30'h0,  1'b0, 30'h0, 1'b0, 30'h91, 1'b1, 1'b0, 10);
    // reset while a trap is pending: target must be discarded, BOOT exits even under stall
    step(200, 1'b1, 1'b1, 1'b0, 30'h0, 1'b1, 30'h500, 1'b0, 30'h91, 1'b1, 1'b0, 10);
    step(201, 1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 30'h0,   1'b0, 30'h0,  1'b0, 1'b0, 0);
    step(202, 1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 30'h0,   1'b0, 30'h0,  1'b1, 1'b0, 0);
    step(203, 1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0,   1'b0, 30'h1,  1'b1, 1'b0, 0);
    step(204, 1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0,   1'b0, 30'h2,  1'b1, 1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_select.md
Name: pc_select

Overview:
- Next-PC generation stage. Sits directly upstream of instruction fetch and produces the word-address PC and pcValid that fetch presents to the instruction bus.
- Selects between boot vector, sequential increment, branch/jump redirect from execute, and trap vector.
- Latches redirects that arrive while the pipeline is stalled, so no control transfer is lost.
- Emits a one-cycle flush pulse to squash wrong-path instructions held in fetch and decode.

Parameters:
- RESET_VECTOR, 30'h0000_0000, word address loaded at reset.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- stall  in  1  pipeline stall. When 1, PC state must not advance.
- redirect_valid_i  in  1  branch/jump taken, from execute.
- redirect_pc_i  in  30  redirect target, word address.
- trap_valid_i  in  1  trap/exception entry.
- trap_pc_i  in  30  trap vector, word address.
- halt_i  in  1  request to stop fetching (WFI/ebreak-halt).
- pc_o  out  30  current fetch PC, registered.
- pc_valid_o  out  1  pc_o is a valid fetch request.
- flush_o  out  1  squash younger in-flight fetch/decode packets.
- redirect_cnt_o  out  CNT_W  number of applied non-sequential PC loads, saturating.

Behaviour:
- Reset: rst is synchronous, active-low, and has priority over stall.
  - On the reset edge: pc_o=RESET_VECTOR, pc_valid_o=0, flush_o=0, redirect_cnt_o=0, pending flags cleared, state=BOOT.
  - Reset mid-operation discards any pending target.
- States:
  - BOOT: pc_valid_o=0. Next edge goes to RUN with pc_o unchanged, regardless of stall.
  - RUN: pc_valid_o=1.
  - PEND: pc_valid_o=1. A target is latched and waits for the stall to release.
  - HALT: pc_valid_o=0 and pc_o holds.
- An "advance edge" is a rising clk edge with stall=0.
- RUN, advance edge, priority trap > redirect > halt > sequential:
  - trap_valid_i: pc_o<=trap_pc_i.
  - redirect_valid_i: pc_o<=redirect_pc_i.
  - halt_i: go to HALT, pc_o holds.
  - Otherwise: pc_o<=pc_o+1, modulo 2^30, so 30'h3fffffff wraps to 0.
- RUN, edge with stall=1:
  - pc_o holds.
  - If trap_valid_i or redirect_valid_i is set: latch pend_pc and pend_is_trap, then go to PEND.
- PEND, edge with stall=1:
  - A new trap overwrites the pending target.
  - A new redirect overwrites only a pending redirect, never a pending trap.
  - halt_i is ignored.
- PEND, advance edge:
  - Source priority: trap_i > pending trap > redirect_i > pending redirect.
  - pc_o<=selected target, pending cleared, go to RUN.
- HALT:
  - Exits only on trap or redirect, under the same stall rules as RUN (stalled input goes to PEND).
  - halt_i is ignored while in HALT.
- flush_o:
  - Registered. flush_o=1 in the cycle after every edge that loads pc_o from a trap/redirect source (RUN, PEND, or HALT path).
  - Otherwise 0, so flush_o is exactly one cycle wide per load.
  - Back-to-back loads give back-to-back pulses.
- redirect_cnt_o: increments on each flush-generating edge. Saturates at all-ones and does not wrap.
- Latency: a redirect presented in cycle N with stall=0 appears on pc_o in cycle N+1. flush_o is also 1 in cycle N+1.
- Sequential increments never assert flush_o.
- Simultaneous trap and redirect: trap wins and the redirect is dropped. The execute stage must not re-present it.
- pc_o must never change while stall=1, including during the BOOT→RUN transition.

Test Plan:
- Reset then release, stall=0:
  - Cycle 1 after reset: pc_o=0, pc_valid_o=0.
  - Following cycles: pc_o=0,1,2,3, pc_valid_o=1, flush_o=0.
- Redirect: redirect_valid_i=1, redirect_pc_i=30'h100 for 1 cycle, stall=0.
  - Next cycle: pc_o=30'h100, flush_o=1, redirect_cnt_o=1.
  - Then pc_o=30'h101, flush_o=0.
- Redirect during stall:
  - Stall held 3 cycles. A redirect to 30'h40 is pulsed in stall cycle 1, then a trap to 30'h200 in stall cycle 2.
  - pc_o holds throughout.
  - After release: pc_o=30'h200, single flush pulse, then 30'h201.
- Wrap: force pc_o=30'h3ffffffe via redirect, run free.
  - pc_o sequence 3ffffffe, 3fffffff, 0, with no flush on the wrap.
- Halt: assert halt_i in RUN.
  - pc_valid_o=0 and pc_o frozen for 10 cycles.
  - Redirect to 30'h80: pc_o=30'h80, pc_valid_o=1, flush_o=1.
- Reset mid-PEND: reset while stalled with a pending trap.
  - pc_o=RESET_VECTOR, no flush after reset, and the pending target is never applied.
